// File: rtl/elevator_call_latch_if.sv
// Bundles the signals between the call latch and its neighbours:
// buttons and car status go in, and the selected call and pending set come out.
interface elevator_call_latch_if #(
  parameter int NUM_FLOORS = 4
);
  logic [NUM_FLOORS-1:0] btn;
  logic [NUM_FLOORS-1:0] cur_floor;
  logic                  car_idle;
  logic                  served;
  logic [NUM_FLOORS-1:0] call_out;
  logic                  call_valid;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;

  modport master (
    output btn, cur_floor, car_idle, served,
    input  call_out, call_valid, pending, dir_up
  );

  modport slave (
    input  btn, cur_floor, car_idle, served,
    output call_out, call_valid, pending, dir_up
  );
endinterface

// File: rtl/elevator_call_latch.sv
// Floor call front end: synchronises and debounces the buttons, latches presses as
// pending calls, and picks the next call to serve in SCAN order.
module elevator_call_latch #(
  parameter int NUM_FLOORS      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elevator_call_latch_if.slave call_if
);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_FLOORS-1:0] FL_ONE   = NUM_FLOORS'(1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} state_t;

  logic [NUM_FLOORS-1:0] sync1_q, sync2_q;
  logic [NUM_FLOORS-1:0] level_q, level_d, level_prev_q;
  logic [CNT_W-1:0]      cnt_q [NUM_FLOORS];
  logic [CNT_W-1:0]      cnt_d [NUM_FLOORS];

  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] call_q, call_d, call_sel;
  logic                  valid_q, valid_d;
  logic                  dir_q, dir_d, dir_sel;
  state_t                state_q, state_d;

  logic                  cur_valid;
  logic [NUM_FLOORS-1:0] rise, set_mask, clr_mask;
  logic [NUM_FLOORS-1:0] below_mask, above_mask, pend_above, pend_below;

  function automatic logic [NUM_FLOORS-1:0] lowest_bit(input logic [NUM_FLOORS-1:0] x);
    logic [NUM_FLOORS-1:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (x[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] highest_bit(input logic [NUM_FLOORS-1:0] x);
    logic [NUM_FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (x[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Debounce: accept the synchronised level only after it has differed for DEBOUNCE_CYCLES.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
      logic differ, expire;
      assign differ      = sync2_q[gi] != level_q[gi];
      assign expire      = differ && (cnt_q[gi] == CNT_LAST);
      assign level_d[gi] = expire ? sync2_q[gi] : level_q[gi];
      assign cnt_d[gi]   = (!differ || expire) ? '0 : cnt_q[gi] + CNT_ONE;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= call_if.btn;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int i = 0; i < NUM_FLOORS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A clear on the served floor overrides a press arriving in the same cycle.
  always_comb begin
    cur_valid = $onehot(call_if.cur_floor);
    rise      = level_q & ~level_prev_q;
    set_mask  = rise & ~(call_if.car_idle ? call_if.cur_floor : '0);
    clr_mask  = (call_if.served && cur_valid) ? call_if.cur_floor : '0;
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_comb begin
    below_mask = call_if.cur_floor - FL_ONE;
    above_mask = ~(below_mask | call_if.cur_floor);
    pend_above = pending_q & above_mask;
    pend_below = pending_q & below_mask;

    state_d  = state_q;
    call_sel = call_q;
    dir_sel  = dir_q;

    unique case (state_q)
      S_IDLE: begin
        call_sel = '0;
        if (|pending_q) state_d = (|pend_above) ? S_UP : S_DN;
      end
      S_UP: begin
        if (|pend_above) begin
          call_sel = lowest_bit(pend_above);
          dir_sel  = 1'b1;
        end else begin
          call_sel = '0;
          state_d  = (|pend_below) ? S_DN : S_IDLE;
        end
      end
      S_DN: begin
        if (|pend_below) begin
          call_sel = highest_bit(pend_below);
          dir_sel  = 1'b0;
        end else begin
          call_sel = '0;
          state_d  = (|pend_above) ? S_UP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Position unknown: freeze the scan. Car moving: freeze what the controller sees.
    if (!cur_valid) state_d = state_q;

    if (call_if.car_idle && cur_valid) begin
      call_d  = call_sel;
      valid_d = |call_sel;
      dir_d   = dir_sel;
    end else begin
      call_d  = call_q;
      valid_d = valid_q;
      dir_d   = dir_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      call_q    <= '0;
      valid_q   <= 1'b0;
      dir_q     <= 1'b1;
      state_q   <= S_IDLE;
    end else begin
      pending_q <= pending_d;
      call_q    <= call_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      state_q   <= state_d;
    end
  end

  assign call_if.pending    = pending_q;
  assign call_if.call_out   = call_q;
  assign call_if.call_valid = valid_q;
  assign call_if.dir_up     = dir_q;

endmodule
